// File: rtl/imem_port_arbiter.sv
// Shares the single program-ROM port between CPU instruction fetch and the UART program loader.
// Define IMEM_LOAD_COUNT_EN to add load_count_o, a saturating count of completed loader writes.
module imem_port_arbiter #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              load_mode_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ack_o,
  output logic [DATA_W-1:0] fetch_data_o,
  input  logic              load_req_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic              load_ack_o,
  output logic              cpu_hold_o,
`ifdef IMEM_LOAD_COUNT_EN
  output logic [ADDR_W:0]   load_count_o,
`endif
  output logic              rom_en_o,
  output logic              rom_we_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic [DATA_W-1:0] rom_wdata_o,
  input  logic [DATA_W-1:0] rom_rdata_i
);

  typedef enum logic [1:0] {StIdle, StFetch, StFetchWait, StLoad} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    fetch_ack_o  = 1'b0;
    fetch_data_o = '0;
    load_ack_o   = 1'b0;
    rom_en_o     = 1'b0;
    rom_we_o     = 1'b0;
    case (state_q)
      StIdle: begin
        if (load_mode_i && load_req_i) begin
          state_d = StLoad;
          addr_d  = load_addr_i;
          wdata_d = load_data_i;
        end else if (!load_mode_i && fetch_req_i) begin
          state_d = StFetch;
          addr_d  = fetch_addr_i;
        end
      end
      StFetch: begin
        rom_en_o = 1'b1;
        state_d  = StFetchWait;
      end
      StFetchWait: begin
        fetch_ack_o  = 1'b1;
        fetch_data_o = rom_rdata_i;
        // Requester presents its next address in the ack cycle, so chain straight into FETCH.
        if (fetch_req_i && !load_mode_i) begin
          state_d = StFetch;
          addr_d  = fetch_addr_i;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        rom_en_o   = 1'b1;
        rom_we_o   = 1'b1;
        load_ack_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Address/data latches double as the ROM drive, so they hold their value while idle.
  assign rom_addr_o  = addr_q;
  assign rom_wdata_o = wdata_q;
  assign cpu_hold_o  = load_mode_i | (state_q == StLoad);

`ifdef IMEM_LOAD_COUNT_EN
  logic              mode_q;
  logic [ADDR_W:0]   count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      mode_q <= load_mode_i;
      if (load_mode_i && !mode_q) begin
        count_q <= '0;
      end else if ((state_q == StLoad) && (count_q != '1)) begin
        count_q <= count_q + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign load_count_o = count_q;
`endif

endmodule
